// File: rtl/floor_request_dispatcher.sv
//------------------------------------------------------------------------------
// floor_request_dispatcher
//
// Upstream stage of the elevator controller. Call buttons are latched into a
// pending-floor bitmap; the next target is picked with SCAN ordering (keep
// moving in the current direction while calls remain ahead, otherwise turn
// around). The target is presented to the elevator core on req_floor and is
// retired when the core reports completion at that floor.
//
// Optional feature (compile-time macro DOOR_DWELL_EN):
//   defined   - after each arrival the block sits in a door-dwell state for
//               DWELL_CYCLES cycles (extended while over_weight is high) with
//               req_valid low before it may dispatch again.
//   undefined - arrival returns straight to IDLE; DWELL_CYCLES only sizes the
//               shared cycle counter.
//
// Ports:
//   clk          in   1           system clock, rising edge
//   rst_n        in   1           asynchronous active-low reset
//   call_btn     in   NUM_FLOORS  call buttons (level), bit i = floor i
//   cur_floor    in   FLOOR_W     current floor reported by the elevator core
//   complete     in   1           elevator core arrival flag
//   over_weight  in   1           elevator core overload flag
//   req_floor    out  FLOOR_W     target floor to the elevator core
//   req_valid    out  1           req_floor is an active target
//   dir_pref     out  2           SCAN direction: 00 idle, 01 up, 10 down
//   pending      out  NUM_FLOORS  latched, unserved calls
//   fault        out  1           sticky: target not reached in time
//------------------------------------------------------------------------------
module floor_request_dispatcher #(
  parameter int NUM_FLOORS     = 8,
  parameter int FLOOR_W        = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int DWELL_CYCLES   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  complete,
  input  logic                  over_weight,
  output logic [FLOOR_W-1:0]    req_floor,
  output logic                  req_valid,
  output logic [1:0]            dir_pref,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  fault
);

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  // One counter serves both the WAIT_DONE timeout and the door dwell; the two
  // never run at the same time, so it is sized for the larger of the two.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > DWELL_CYCLES) ? TIMEOUT_CYCLES : DWELL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`ifdef DOOR_DWELL_EN
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
`ifdef DOOR_DWELL_EN
    , ST_DWELL = 2'd3
`endif
  } state_e;

  state_e                  state_q, state_d;
  logic [FLOOR_W-1:0]      req_floor_q, req_floor_d;
  logic                    req_valid_q, req_valid_d;
  logic [1:0]              dir_q, dir_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic                    fault_q, fault_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    cur_in_range;
  logic [NUM_FLOORS-1:0]   up_mask, dn_mask, rt_mask;
  logic [NUM_FLOORS-1:0]   set_mask, clr_mask;
  logic [FLOOR_W:0]        up_pick, dn_pick, rt_pick;

  // One-hot bitmap for a floor index.
  function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (FLOOR_W'(i) == f) m[i] = 1'b1;
    end
    return m;
  endfunction

  // {found, index} of the lowest set bit: nearest floor above the car.
  function automatic logic [FLOOR_W:0] pick_lowest(input logic [NUM_FLOORS-1:0] m);
    logic [FLOOR_W:0] r;
    r = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (m[i]) r = {1'b1, FLOOR_W'(i)};
    end
    return r;
  endfunction

  // {found, index} of the highest set bit: nearest floor below the car.
  function automatic logic [FLOOR_W:0] pick_highest(input logic [NUM_FLOORS-1:0] m);
    logic [FLOOR_W:0] r;
    r = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (m[i]) r = {1'b1, FLOOR_W'(i)};
    end
    return r;
  endfunction

  // A car position outside the building has no floor ahead in either direction.
  assign cur_in_range = (32'(cur_floor) < NUM_FLOORS);

  // Candidate sets relative to the car: above, below, and (for retargeting)
  // strictly between the car and the current target in the travel direction.
  always_comb begin
    up_mask = '0;
    dn_mask = '0;
    rt_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (cur_in_range && pending_q[i]) begin
        if (FLOOR_W'(i) > cur_floor) up_mask[i] = 1'b1;
        if (FLOOR_W'(i) < cur_floor) dn_mask[i] = 1'b1;
        if ((dir_q == DIR_UP) && (FLOOR_W'(i) > cur_floor) && (FLOOR_W'(i) < req_floor_q))
          rt_mask[i] = 1'b1;
        if ((dir_q == DIR_DOWN) && (FLOOR_W'(i) < cur_floor) && (FLOOR_W'(i) > req_floor_q))
          rt_mask[i] = 1'b1;
      end
    end
  end

  assign up_pick = pick_lowest(up_mask);
  assign dn_pick = pick_highest(dn_mask);
  // Retarget to the in-between floor closest to the car.
  assign rt_pick = (dir_q == DIR_DOWN) ? pick_highest(rt_mask) : pick_lowest(rt_mask);

  always_comb begin
    state_d     = state_q;
    req_floor_d = req_floor_q;
    req_valid_d = req_valid_q;
    dir_d       = dir_q;
    fault_d     = fault_q;
    cnt_d       = cnt_q;
    set_mask    = call_btn;
    clr_mask    = '0;

    case (state_q)
      ST_IDLE: begin
        // Standing at a floor: a call for that same floor needs no trip.
        if (cur_in_range) set_mask = call_btn & ~floor_bit(cur_floor);
        if (pending_q == '0) begin
          dir_d = DIR_IDLE;
        end else if (!over_weight && !fault_q) begin
          if (dir_q == DIR_DOWN) begin
            if (dn_pick[FLOOR_W]) begin
              req_floor_d = dn_pick[FLOOR_W-1:0];
              dir_d       = DIR_DOWN;
              req_valid_d = 1'b1;
              state_d     = ST_WAIT;
              cnt_d       = '0;
            end else if (up_pick[FLOOR_W]) begin
              req_floor_d = up_pick[FLOOR_W-1:0];
              dir_d       = DIR_UP;
              req_valid_d = 1'b1;
              state_d     = ST_WAIT;
              cnt_d       = '0;
            end
          end else begin
            // Moving up, or idle: up is tried first.
            if (up_pick[FLOOR_W]) begin
              req_floor_d = up_pick[FLOOR_W-1:0];
              dir_d       = DIR_UP;
              req_valid_d = 1'b1;
              state_d     = ST_WAIT;
              cnt_d       = '0;
            end else if (dn_pick[FLOOR_W]) begin
              req_floor_d = dn_pick[FLOOR_W-1:0];
              dir_d       = DIR_DOWN;
              req_valid_d = 1'b1;
              state_d     = ST_WAIT;
              cnt_d       = '0;
            end
          end
        end
      end

      ST_WAIT: begin
        if (over_weight) begin
          // Overload outranks arrival and retarget; the timeout count is kept.
          req_valid_d = 1'b0;
          state_d     = ST_HOLD;
        end else if (complete && (cur_floor == req_floor_q)) begin
          clr_mask    = floor_bit(req_floor_q);
          req_valid_d = 1'b0;
          cnt_d       = '0;
`ifdef DOOR_DWELL_EN
          state_d     = ST_DWELL;
`else
          state_d     = ST_IDLE;
`endif
        end else if (cnt_q == TMO_LAST) begin
          fault_d     = 1'b1;
          clr_mask    = floor_bit(req_floor_q);
          req_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // The superseded target stays in pending and is picked up later.
          if (rt_pick[FLOOR_W]) req_floor_d = rt_pick[FLOOR_W-1:0];
        end
      end

      ST_HOLD: begin
        req_valid_d = 1'b0;
        if (!over_weight) begin
          req_valid_d = 1'b1;
          state_d     = ST_WAIT;
        end
      end

`ifdef DOOR_DWELL_EN
      ST_DWELL: begin
        // Overload holds the doors open: the dwell count pauses.
        if (!over_weight) begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`endif

      default: begin
        req_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    // Clear wins over a same-cycle set; a held button re-latches next cycle.
    pending_d = (pending_q | set_mask) & ~clr_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_floor_q <= '0;
      req_valid_q <= 1'b0;
      dir_q       <= DIR_IDLE;
      pending_q   <= '0;
      fault_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_floor_q <= req_floor_d;
      req_valid_q <= req_valid_d;
      dir_q       <= dir_d;
      pending_q   <= pending_d;
      fault_q     <= fault_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_floor = req_floor_q;
  assign req_valid = req_valid_q;
  assign dir_pref  = dir_q;
  assign pending   = pending_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_floor_request_dispatcher.sv
module tb_floor_request_dispatcher;

  localparam int NF    = 8;
  localparam int FW    = 3;
  localparam int TMO   = 40;
  localparam int DWELL = 8;
`ifdef DOOR_DWELL_EN
  localparam int POST_ARR = DWELL;
`else
  localparam int POST_ARR = 0;
`endif

  localparam int MD_IDLE  = 0;
  localparam int MD_WAIT  = 1;
  localparam int MD_HOLD  = 2;
  localparam int MD_DWELL = 3;

  logic          clk;
  logic          rst_n;
  logic [NF-1:0] call_btn;
  logic [FW-1:0] cur_floor;
  logic          complete;
  logic          over_weight;
  logic [FW-1:0] req_floor;
  logic          req_valid;
  logic [1:0]    dir_pref;
  logic [NF-1:0] pending;
  logic          fault;

  int checks = 0;
  int errors = 0;

  floor_request_dispatcher #(
    .NUM_FLOORS    (NF),
    .FLOOR_W       (FW),
    .TIMEOUT_CYCLES(TMO),
    .DWELL_CYCLES  (DWELL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .call_btn   (call_btn),
    .cur_floor  (cur_floor),
    .complete   (complete),
    .over_weight(over_weight),
    .req_floor  (req_floor),
    .req_valid  (req_valid),
    .dir_pref   (dir_pref),
    .pending    (pending),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_req, m_mode, m_elapsed, m_dwell_left;
  bit          m_valid, m_fault;
  bit [1:0]    m_dir;
  bit [NF-1:0] m_pend;

  // nearest pending floor f with cur < f < lim, or -1
  function automatic int near_up(input bit [NF-1:0] p, input int cur, input int lim);
    if (cur >= NF) return -1;
    for (int f = cur + 1; f < lim; f++) if (p[f]) return f;
    return -1;
  endfunction

  // nearest pending floor f with lim < f < cur, or -1
  function automatic int near_dn(input bit [NF-1:0] p, input int cur, input int lim);
    if (cur >= NF) return -1;
    for (int f = cur - 1; f > lim; f--) if (p[f]) return f;
    return -1;
  endfunction

  task automatic model_step();
    bit [NF-1:0] calls, clr;
    bit [1:0]    nd;
    int cur, up, dn, tgt, nxt;
    cur   = int'(cur_floor);
    calls = call_btn;
    clr   = '0;
    case (m_mode)
      MD_IDLE: begin
        if (cur < NF) calls[cur] = 1'b0;
        if (m_pend == '0) m_dir = 2'b00;
        else if (!over_weight && !m_fault) begin
          up  = near_up(m_pend, cur, NF);
          dn  = near_dn(m_pend, cur, -1);
          tgt = -1;
          nd  = m_dir;
          if (m_dir == 2'b10) begin
            if (dn >= 0) begin tgt = dn; nd = 2'b10; end
            else if (up >= 0) begin tgt = up; nd = 2'b01; end
          end else begin
            if (up >= 0) begin tgt = up; nd = 2'b01; end
            else if (dn >= 0) begin tgt = dn; nd = 2'b10; end
          end
          if (tgt >= 0) begin
            m_req = tgt; m_valid = 1'b1; m_dir = nd; m_mode = MD_WAIT; m_elapsed = 0;
          end
        end
      end
      MD_WAIT: begin
        if (over_weight) begin
          m_mode = MD_HOLD; m_valid = 1'b0;
        end else if (complete && cur == m_req) begin
          clr[m_req] = 1'b1; m_valid = 1'b0;
`ifdef DOOR_DWELL_EN
          m_mode = MD_DWELL; m_dwell_left = DWELL;
`else
          m_mode = MD_IDLE;
`endif
        end else begin
          m_elapsed++;
          if (m_elapsed >= TMO) begin
            m_fault = 1'b1; clr[m_req] = 1'b1; m_valid = 1'b0; m_mode = MD_IDLE;
          end else begin
            if (m_dir == 2'b01) nxt = near_up(m_pend, cur, m_req);
            else if (m_dir == 2'b10) nxt = near_dn(m_pend, cur, m_req);
            else nxt = -1;
            if (nxt >= 0) m_req = nxt;
          end
        end
      end
      MD_HOLD: begin
        if (!over_weight) begin m_mode = MD_WAIT; m_valid = 1'b1; end
      end
      default: begin
        if (!over_weight) begin
          m_dwell_left--;
          if (m_dwell_left == 0) m_mode = MD_IDLE;
        end
      end
    endcase
    m_pend = (m_pend | calls) & ~clr;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req = 0; m_mode = MD_IDLE; m_elapsed = 0; m_dwell_left = 0;
      m_valid = 1'b0; m_fault = 1'b0; m_dir = 2'b00; m_pend = '0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    cmp("model_req_floor", int'(req_floor), m_req);
    cmp("model_req_valid", int'(req_valid), int'(m_valid));
    cmp("model_dir_pref", int'(dir_pref), int'(m_dir));
    cmp("model_pending", int'(pending), int'(m_pend));
    cmp("model_fault", int'(fault), int'(m_fault));
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic arrive(input int f);
    cur_floor = FW'(f);
    complete  = 1'b1;
    step(1);
    complete  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; call_btn = '0; cur_floor = '0; complete = 1'b0; over_weight = 1'b0;
    step(2);
    cmp("rst_req_floor", int'(req_floor), 0);
    cmp("rst_req_valid", int'(req_valid), 0);
    cmp("rst_dir", int'(dir_pref), 0);
    cmp("rst_pending", int'(pending), 0);
    cmp("rst_fault", int'(fault), 0);
    rst_n = 1'b1;
    step(1);

    // single up call
    cur_floor = 3'd1; call_btn = 8'h20; step(1); call_btn = '0;
    cmp("t1_pending", int'(pending), 'h20);
    cmp("t1_valid_pre", int'(req_valid), 0);
    step(1);
    cmp("t1_req", int'(req_floor), 5);
    cmp("t1_valid", int'(req_valid), 1);
    cmp("t1_dir", int'(dir_pref), 1);
    arrive(5);
    cmp("t1_pending_done", int'(pending), 0);
    cmp("t1_valid_done", int'(req_valid), 0);
    step(1 + POST_ARR);
    cmp("t1_dir_idle", int'(dir_pref), 0);

    // call for the floor the idle car stands at is dropped
    call_btn = 8'h20; step(1); call_btn = '0;
    cmp("same_floor_pending", int'(pending), 0);
    step(1);
    cmp("same_floor_valid", int'(req_valid), 0);

    // two calls in one cycle: nearest first, direction kept
    cur_floor = 3'd0; call_btn = 8'h88; step(1); call_btn = '0;
    cmp("t2_pending", int'(pending), 'h88);
    step(1);
    cmp("t2_req_first", int'(req_floor), 3);
    cmp("t2_dir_first", int'(dir_pref), 1);
    arrive(3);
    cmp("t2_pending_mid", int'(pending), 'h80);
    cmp("t2_valid_mid", int'(req_valid), 0);
    step(1 + POST_ARR);
    cmp("t2_req_second", int'(req_floor), 7);
    cmp("t2_valid_second", int'(req_valid), 1);
    cmp("t2_dir_second", int'(dir_pref), 1);

    // turn-around: only a call below remains, direction flips
    cur_floor = 3'd7; complete = 1'b1; call_btn = 8'h04; step(1);
    complete = 1'b0; call_btn = '0;
    cmp("flip_pending", int'(pending), 'h04);
    step(1 + POST_ARR);
    cmp("flip_req", int'(req_floor), 2);
    cmp("flip_dir", int'(dir_pref), 2);
    // downward retarget
    cur_floor = 3'd6; call_btn = 8'h10; step(1); call_btn = '0;
    cmp("down_rt_pending", int'(pending), 'h14);
    step(1);
    cmp("down_rt_req", int'(req_floor), 4);
    arrive(4);
    cmp("down_rt_pending_done", int'(pending), 'h04);
    step(1 + POST_ARR);
    cmp("down_rt_req_next", int'(req_floor), 2);
    cmp("down_rt_dir_next", int'(dir_pref), 2);
    arrive(2);
    cmp("down_pending_empty", int'(pending), 0);
    step(1 + POST_ARR);

    // upward retarget, old target kept pending
    cur_floor = 3'd2; call_btn = 8'h80; step(1); call_btn = '0; step(1);
    cmp("t3_req7", int'(req_floor), 7);
    cmp("t3_dir", int'(dir_pref), 1);
    call_btn = 8'h20; step(1); call_btn = '0; step(1);
    cmp("t3_req5", int'(req_floor), 5);
    cmp("t3_pending", int'(pending), 'hA0);
    arrive(5);
    cmp("t3_pending_after5", int'(pending), 'h80);
    step(1 + POST_ARR);
    cmp("t3_req7_again", int'(req_floor), 7);
    cmp("t3_valid7", int'(req_valid), 1);
    arrive(7);
    step(1 + POST_ARR);

    // overload hold
    cur_floor = 3'd1; call_btn = 8'h20; step(1); call_btn = '0; step(1);
    cmp("t4_req", int'(req_floor), 5);
    over_weight = 1'b1; step(1);
    cmp("t4_valid_hold", int'(req_valid), 0);
    cur_floor = 3'd5; complete = 1'b1; step(9);
    cmp("t4_valid_hold_end", int'(req_valid), 0);
    cmp("t4_req_held", int'(req_floor), 5);
    cmp("t4_pending_held", int'(pending), 'h20);
    over_weight = 1'b0; complete = 1'b0; step(1);
    cmp("t4_valid_resume", int'(req_valid), 1);
    cmp("t4_req_resume", int'(req_floor), 5);
    arrive(5);
    cmp("t4_pending_done", int'(pending), 0);
    step(1 + POST_ARR);

    // timeout fault
    cur_floor = 3'd0; call_btn = 8'h10; step(1); call_btn = '0; step(1);
    cmp("t5_req", int'(req_floor), 4);
    step(TMO - 1);
    cmp("t5_fault_early", int'(fault), 0);
    cmp("t5_valid_early", int'(req_valid), 1);
    step(1);
    cmp("t5_fault", int'(fault), 1);
    cmp("t5_pending", int'(pending), 0);
    cmp("t5_valid", int'(req_valid), 0);
    call_btn = 8'h04; step(1); call_btn = '0;
    cmp("t5_latch_after_fault", int'(pending), 'h04);
    step(5);
    cmp("t5_no_dispatch", int'(req_valid), 0);
    cmp("t5_fault_sticky", int'(fault), 1);

    // asynchronous reset mid-WAIT_DONE
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    cmp("t6_fault_cleared", int'(fault), 0);
    cur_floor = 3'd4; call_btn = 8'h48; step(1); call_btn = '0; step(1);
    cmp("t6_req", int'(req_floor), 6);
    cmp("t6_valid", int'(req_valid), 1);
    cmp("t6_pending", int'(pending), 'h48);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("t6_async_req", int'(req_floor), 0);
    cmp("t6_async_valid", int'(req_valid), 0);
    cmp("t6_async_dir", int'(dir_pref), 0);
    cmp("t6_async_pending", int'(pending), 0);
    cmp("t6_async_fault", int'(fault), 0);
    step(1);
    rst_n = 1'b1;
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
